// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions: opcode encodings, addressing-mode
//                constants, instruction-register field positions and the
//                fetch-stage state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcode encodings (IR[31:28])
    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    // Addressing mode: immediate
    localparam logic [3:0] AM_IMM  = 4'd8;

    // Instruction-register field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int MM_MSB     = 27;
    localparam int MM_LSB     = 24;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;

    // Fetch-stage states
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_calc
//  Description : Combinational next-PC computation. The base is PC or PC+1
//                (inc_en); a branch (br_en) replaces it with either the
//                absolute target IMM[ADDR_W-1:0] (br_sel=1) or the relative
//                target base+sext(IMM) (br_sel=0), wrapping mod 2^ADDR_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [IMM_W-1:0]  imm,
    input  logic              br_sel,
    input  logic              inc_en,
    input  logic              br_en,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] imm_sext;
    logic [ADDR_W-1:0] imm_abs;
    logic [ADDR_W-1:0] pc_base;

    // Immediate sign-extended to (or truncated to) the address width
    generate
        if (ADDR_W > IMM_W) begin : g_imm_wide
            assign imm_sext = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
            assign imm_abs  = {{(ADDR_W-IMM_W){1'b0}}, imm};
        end else begin : g_imm_narrow
            assign imm_sext = imm[ADDR_W-1:0];
            assign imm_abs  = imm[ADDR_W-1:0];
        end
    endgenerate

    // Select sequential, relative or absolute next PC
    always_comb begin
        pc_base = pc + {{(ADDR_W-1){1'b0}}, inc_en};
        pc_next = pc_base;
        if (br_en) begin
            pc_next = br_sel ? imm_abs : (pc_base + imm_sext);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns PC and IR, runs the req/ack
//                handshake to instruction memory and applies the controller's
//                fetch / branch / PC-reset commands (edge-triggered).
//  Options     : FETCH_TIMEOUT_EN - abort a fetch after TIMEOUT cycles
//                without ACK, load a noop and raise sticky FETCH_ERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic               CLK,
    input  logic               RST_F,
    input  logic               PC_RST,
    input  logic               PC_WRITE,
    input  logic               PC_SEL,
    input  logic               BR_SEL,
    output logic               IMEM_REQ,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic               IMEM_ACK,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    output logic [3:0]         OPCODE,
    output logic [3:0]         MM,
    output logic [INSTR_W-1:0] IR,
    output logic [ADDR_W-1:0]  PC,
    output logic               FETCH_BUSY,
    output logic               FETCH_ERR
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               wr_prev_q, wr_prev_d;
    logic               sel_prev_q, sel_prev_d;
    logic               pend_q, pend_d;
    logic               pend_sel_q, pend_sel_d;

    logic               wr_rise;
    logic               sel_rise;

    logic [IMM_W-1:0]   calc_imm;
    logic               calc_br_sel;
    logic               calc_inc_en;
    logic               calc_br_en;
    logic [ADDR_W-1:0]  calc_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    assign wr_rise  = PC_WRITE & ~wr_prev_q;
    assign sel_rise = PC_SEL   & ~sel_prev_q;

    // Single shared next-PC datapath; operands steered by the FSM below
    pc_next_calc #(
        .ADDR_W  (ADDR_W)
    ) u_pc_next_calc (
        .pc      (pc_q),
        .imm     (calc_imm),
        .br_sel  (calc_br_sel),
        .inc_en  (calc_inc_en),
        .br_en   (calc_br_en),
        .pc_next (calc_pc)
    );

    // Next-state, handshake and PC/IR update logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        req_d       = req_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        wr_prev_d   = PC_WRITE;
        sel_prev_d  = PC_SEL;
        pend_d      = pend_q;
        pend_sel_d  = pend_sel_q;
        calc_imm    = ir_q[IMM_MSB:IMM_LSB];
        calc_br_sel = BR_SEL;
        calc_inc_en = 1'b0;
        calc_br_en  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif

        case (state_q)
            IDLE: begin
                // Branch uses the current IR and the already-incremented PC;
                // with no branch calc_pc is simply pc_q, so a simultaneous
                // fetch is issued at whichever address results.
                calc_br_en = sel_rise;
                if (sel_rise) begin
                    pc_d = calc_pc;
                end
                if (wr_rise) begin
                    state_d = WAIT_ACK;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    addr_d  = calc_pc;
                end
`ifdef FETCH_TIMEOUT_EN
                cnt_d = '0;
`endif
            end

            WAIT_ACK: begin
                // On ACK the target comes from the incoming word and PC+1
                calc_imm    = IMEM_RDATA[IMM_MSB:IMM_LSB];
                calc_inc_en = 1'b1;
                calc_br_en  = pend_q | sel_rise;
                calc_br_sel = sel_rise ? BR_SEL : pend_sel_q;
                if (sel_rise) begin
                    pend_d     = 1'b1;
                    pend_sel_d = BR_SEL;
                end
                if (IMEM_ACK) begin
                    ir_d    = IMEM_RDATA;
                    pc_d    = calc_pc;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ir_d    = '0;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    pend_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Controller-issued clear wins over everything, including a fetch
        if (PC_RST) begin
            state_d    = IDLE;
            pc_d       = RESET_PC;
            ir_d       = '0;
            req_d      = 1'b0;
            addr_d     = '0;
            busy_d     = 1'b0;
            wr_prev_d  = 1'b0;
            sel_prev_d = 1'b0;
            pend_d     = 1'b0;
            pend_sel_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_d      = '0;
            err_d      = 1'b0;
`endif
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            wr_prev_q  <= 1'b0;
            sel_prev_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            wr_prev_q  <= wr_prev_d;
            sel_prev_q <= sel_prev_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Timeout counter and sticky error flag
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign FETCH_ERR = err_q;
`else
    assign FETCH_ERR = 1'b0;
`endif

    assign IMEM_REQ   = req_q;
    assign IMEM_ADDR  = addr_q;
    assign IR         = ir_q;
    assign OPCODE     = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign MM         = ir_q[MM_MSB:MM_LSB];
    assign PC         = pc_q;
    assign FETCH_BUSY = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_F;
    logic        PC_RST;
    logic        PC_WRITE;
    logic        PC_SEL;
    logic        BR_SEL;
    logic        IMEM_REQ;
    logic [15:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic [3:0]  OPCODE;
    logic [3:0]  MM;
    logic [31:0] IR;
    logic [15:0] PC;
    logic        FETCH_BUSY;
    logic        FETCH_ERR;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .CLK        (CLK),
        .RST_F      (RST_F),
        .PC_RST     (PC_RST),
        .PC_WRITE   (PC_WRITE),
        .PC_SEL     (PC_SEL),
        .BR_SEL     (BR_SEL),
        .IMEM_REQ   (IMEM_REQ),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_ACK   (IMEM_ACK),
        .IMEM_RDATA (IMEM_RDATA),
        .OPCODE     (OPCODE),
        .MM         (MM),
        .IR         (IR),
        .PC         (PC),
        .FETCH_BUSY (FETCH_BUSY),
        .FETCH_ERR  (FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle; outputs are checked and new
    // inputs driven at this point, well away from the next edge.
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset();
        RST_F = 1'b0; PC_RST = 1'b0; PC_WRITE = 1'b0; PC_SEL = 1'b0;
        BR_SEL = 1'b0; IMEM_ACK = 1'b0; IMEM_RDATA = '0;
        step(); step();
        RST_F = 1'b1;
        step();
        total++; if (PC !== 16'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0000", PC); end
        total++; if (IR !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h exp=00000000", IR); end
        total++; if (OPCODE !== 4'h0) begin bad++; $display("FAIL reset_opcode got=%h exp=0", OPCODE); end
        total++; if (IMEM_REQ !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", IMEM_REQ); end
        total++; if (FETCH_BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", FETCH_BUSY); end
        total++; if (FETCH_ERR !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", FETCH_ERR); end
    endtask

    task automatic test_basic_fetch();
        PC_WRITE = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            total++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 16'h0 || FETCH_BUSY !== 1'b1)
                begin bad++; $display("FAIL basic_wait%0d req=%b addr=%h busy=%b exp 1/0000/1", i, IMEM_REQ, IMEM_ADDR, FETCH_BUSY); end
            total++; if (IR !== 32'h0) begin bad++; $display("FAIL basic_ir_stable%0d got=%h exp=00000000", i, IR); end
            if (i == 2) begin IMEM_ACK = 1'b1; IMEM_RDATA = 32'h8800_0005; end
            step();
        end
        IMEM_ACK = 1'b0;
        total++; if (OPCODE !== 4'h8 || MM !== 4'h8) begin bad++; $display("FAIL basic_fields op=%h mm=%h exp 8/8", OPCODE, MM); end
        total++; if (PC !== 16'h1) begin bad++; $display("FAIL basic_pc got=%h exp=0001", PC); end
        total++; if (FETCH_BUSY !== 1'b0 || IMEM_REQ !== 1'b0) begin bad++; $display("FAIL basic_done busy=%b req=%b exp 0/0", FETCH_BUSY, IMEM_REQ); end
        // PC_WRITE still high: no second fetch may start
        step();
        total++; if (IMEM_REQ !== 1'b0) begin bad++; $display("FAIL basic_level_hold req=%b exp=0", IMEM_REQ); end
        PC_WRITE = 1'b0;
        step();
    endtask

    task automatic test_min_latency();
        logic [31:0] words [4];
        words[0] = 32'h1100_0001; words[1] = 32'h2200_0002;
        words[2] = 32'h8800_0003; words[3] = 32'h5000_FFFE;
        for (int i = 0; i < 4; i++) begin
            PC_WRITE = 1'b1;
            step();
            total++; if (IMEM_ADDR !== 16'(1 + i)) begin bad++; $display("FAIL lat_addr%0d got=%h exp=%h", i, IMEM_ADDR, 16'(1 + i)); end
            IMEM_ACK = 1'b1; IMEM_RDATA = words[i];
            step();
            total++; if (IR !== words[i] || PC !== 16'(2 + i))
                begin bad++; $display("FAIL lat_ir%0d ir=%h pc=%h exp %h/%h", i, IR, PC, words[i], 16'(2 + i)); end
            IMEM_ACK = 1'b0; PC_WRITE = 1'b0;
            step();
        end
    endtask

    task automatic test_rel_branch();
        // PC=5, IMM=0xFFFE -> 5-2 = 3
        BR_SEL = 1'b0; PC_SEL = 1'b1;
        step();
        total++; if (PC !== 16'h3) begin bad++; $display("FAIL rel_branch got=%h exp=0003", PC); end
        repeat (4) step();
        total++; if (PC !== 16'h3) begin bad++; $display("FAIL rel_hold got=%h exp=0003", PC); end
        PC_SEL = 1'b0;
        step();
        // Another rise: 3-2 = 1
        PC_SEL = 1'b1;
        step();
        total++; if (PC !== 16'h1) begin bad++; $display("FAIL rel_branch2 got=%h exp=0001", PC); end
        PC_SEL = 1'b0;
        PC_WRITE = 1'b1;
        step();
        IMEM_ACK = 1'b1; IMEM_RDATA = 32'h0;
        step();
        IMEM_ACK = 1'b0; PC_WRITE = 1'b0;
        step();
        total++; if (PC !== 16'h2) begin bad++; $display("FAIL rel_refetch_pc got=%h exp=0002", PC); end
    endtask

    task automatic test_abs_branch_during_fetch();
        PC_WRITE = 1'b1;
        step();
        BR_SEL = 1'b1; PC_SEL = 1'b1;
        step();
        total++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 16'h2 || PC !== 16'h2)
            begin bad++; $display("FAIL abs_pending req=%b addr=%h pc=%h exp 1/0002/0002", IMEM_REQ, IMEM_ADDR, PC); end
        // Captured BR_SEL must be used even though the live input changes
        BR_SEL = 1'b0; IMEM_ACK = 1'b1; IMEM_RDATA = 32'h4000_0040;
        step();
        total++; if (PC !== 16'h0040) begin bad++; $display("FAIL abs_branch_pc got=%h exp=0040", PC); end
        total++; if (IR !== 32'h4000_0040 || FETCH_BUSY !== 1'b0)
            begin bad++; $display("FAIL abs_branch_ir ir=%h busy=%b exp 40000040/0", IR, FETCH_BUSY); end
        IMEM_ACK = 1'b0; PC_WRITE = 1'b0; PC_SEL = 1'b0;
        step();
    endtask

    task automatic test_branch_on_ack_edge();
        // PC=0x40, relative IMM=0x0010 -> 0x41+0x10 = 0x51
        PC_WRITE = 1'b1;
        step();
        IMEM_ACK = 1'b1; IMEM_RDATA = 32'h4000_0010; PC_SEL = 1'b1; BR_SEL = 1'b0;
        step();
        total++; if (PC !== 16'h0051) begin bad++; $display("FAIL ack_edge_branch got=%h exp=0051", PC); end
        IMEM_ACK = 1'b0; PC_WRITE = 1'b0; PC_SEL = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        // IDLE: fetch and absolute branch on the same edge -> fetch at 0x10
        BR_SEL = 1'b1; PC_SEL = 1'b1; PC_WRITE = 1'b1;
        step();
        total++; if (IMEM_ADDR !== 16'h0010 || PC !== 16'h0010 || IMEM_REQ !== 1'b1)
            begin bad++; $display("FAIL wr_sel_same addr=%h pc=%h req=%b exp 0010/0010/1", IMEM_ADDR, PC, IMEM_REQ); end
        PC_SEL = 1'b0; PC_WRITE = 1'b0;
        step();
        PC_WRITE = 1'b1;   // rise while waiting: must be ignored
        step();
        total++; if (IMEM_ADDR !== 16'h0010 || IMEM_REQ !== 1'b1)
            begin bad++; $display("FAIL wr_in_wait addr=%h req=%b exp 0010/1", IMEM_ADDR, IMEM_REQ); end
        IMEM_ACK = 1'b1; IMEM_RDATA = 32'h0000_0003;
        step();
        IMEM_ACK = 1'b0;
        total++; if (PC !== 16'h0011) begin bad++; $display("FAIL b2b_pc got=%h exp=0011", PC); end
        step();
        total++; if (IMEM_REQ !== 1'b0) begin bad++; $display("FAIL no_queue req=%b exp=0", IMEM_REQ); end
        PC_WRITE = 1'b0;
        step();
    endtask

    task automatic test_pc_rst_mid_fetch();
        PC_WRITE = 1'b1;
        step();
        total++; if (IMEM_ADDR !== 16'h0011) begin bad++; $display("FAIL rst_fetch_addr got=%h exp=0011", IMEM_ADDR); end
        PC_RST = 1'b1; PC_WRITE = 1'b0;
        step();
        total++; if (PC !== 16'h0 || IR !== 32'h0 || IMEM_REQ !== 1'b0 || FETCH_BUSY !== 1'b0)
            begin bad++; $display("FAIL pc_rst pc=%h ir=%h req=%b busy=%b exp 0000/0/0/0", PC, IR, IMEM_REQ, FETCH_BUSY); end
        PC_RST = 1'b0; IMEM_ACK = 1'b1; IMEM_RDATA = 32'hF000_1234;
        step();
        IMEM_ACK = 1'b0;
        total++; if (PC !== 16'h0 || IR !== 32'h0 || IMEM_REQ !== 1'b0)
            begin bad++; $display("FAIL late_ack pc=%h ir=%h req=%b exp 0000/0/0", PC, IR, IMEM_REQ); end
        step();
    endtask

    task automatic test_timeout();
        // Load a non-zero IR first (PC 0 -> 1)
        PC_WRITE = 1'b1;
        step();
        IMEM_ACK = 1'b1; IMEM_RDATA = 32'h1234_5678;
        step();
        IMEM_ACK = 1'b0; PC_WRITE = 1'b0;
        step();
        PC_WRITE = 1'b1;
        step();
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 14; i++) step();
        total++; if (IMEM_REQ !== 1'b1 || FETCH_ERR !== 1'b0)
            begin bad++; $display("FAIL timeout_early req=%b err=%b exp 1/0", IMEM_REQ, FETCH_ERR); end
        step();
        total++; if (IMEM_REQ !== 1'b0 || IR !== 32'h0 || FETCH_ERR !== 1'b1 || PC !== 16'h1)
            begin bad++; $display("FAIL timeout req=%b ir=%h err=%b pc=%h exp 0/0/1/0001", IMEM_REQ, IR, FETCH_ERR, PC); end
`else
        for (int i = 0; i < 20; i++) step();
        total++; if (IMEM_REQ !== 1'b1 || FETCH_ERR !== 1'b0 || IR !== 32'h1234_5678)
            begin bad++; $display("FAIL no_timeout req=%b err=%b ir=%h exp 1/0/12345678", IMEM_REQ, FETCH_ERR, IR); end
        IMEM_ACK = 1'b1; IMEM_RDATA = 32'h2000_0000;
        step();
        IMEM_ACK = 1'b0;
        total++; if (PC !== 16'h2 || IMEM_REQ !== 1'b0)
            begin bad++; $display("FAIL slow_ack pc=%h req=%b exp 0002/0", PC, IMEM_REQ); end
`endif
        PC_WRITE = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_min_latency();
        test_rel_branch();
        test_abs_branch_during_fetch();
        test_branch_on_ack_edge();
        test_back_to_back();
        test_pc_rst_mid_fetch();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle control FSM.
- Owns the program counter (PC) and the instruction register (IR), and runs the req/ack handshake to instruction memory.
- Supplies OPCODE/MM to the controller and applies the controller's PC_WRITE/PC_SEL/BR_SEL/PC_RST commands.

Parameters:
- ADDR_W, 16, PC and instruction-memory word-address width.
- INSTR_W, 32, instruction width; OPCODE=IR[31:28], MM=IR[27:24], IMM=IR[15:0].
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, cycles allowed for IMEM_ACK (only used with FETCH_TIMEOUT_EN).

Ports:
- CLK  in  1  clock, rising edge.
- RST_F  in  1  reset, asynchronous, active-low.
- PC_RST  in  1  synchronous PC/IR clear from controller.
- PC_WRITE  in  1  level; rising edge starts a fetch at the current PC.
- PC_SEL  in  1  level; rising edge applies a branch.
- BR_SEL  in  1  branch type: 1=absolute (PC<=IMM), 0=relative (PC<=PC+sext(IMM)).
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  ADDR_W  fetch address.
- IMEM_ACK  in  1  memory data valid.
- IMEM_RDATA  in  INSTR_W  instruction word.
- OPCODE  out  4  IR[31:28].
- MM  out  4  IR[27:24].
- IR  out  INSTR_W  full instruction register.
- PC  out  ADDR_W  current PC.
- FETCH_BUSY  out  1  high while a fetch is outstanding; controller stalls on it.
- FETCH_ERR  out  1  sticky timeout flag (only with macro; tied 0 otherwise).

Behaviour:
- Reset (RST_F low, async):
  - PC=RESET_PC, IR=0 (OPCODE=noop), IMEM_REQ=0, FETCH_BUSY=0, FETCH_ERR=0.
  - State IDLE; edge-detect registers for PC_WRITE/PC_SEL cleared to 0.
- PC_RST=1 at a clock edge: same values as reset, synchronously. Overrides every other input, including an outstanding fetch, which is dropped; a late ACK is ignored.
- Edge detection: registered copies of PC_WRITE and PC_SEL. wr_rise=PC_WRITE&~prev and sel_rise=PC_SEL&~prev, each one cycle wide. Holding a level high never repeats an action.
- FSM states:
  - IDLE: on wr_rise go to WAIT_ACK. IMEM_REQ=1 and IMEM_ADDR=PC are registered, so both are valid the cycle after wr_rise. FETCH_BUSY=1.
  - WAIT_ACK: hold IMEM_REQ and IMEM_ADDR stable. When IMEM_ACK=1 at an edge: IR<=IMEM_RDATA, PC<=PC+1 (mod 2^ADDR_W), IMEM_REQ<=0, FETCH_BUSY<=0, return to IDLE.
- Minimum fetch latency: 2 cycles from wr_rise to IR update, with ACK returned in the first REQ cycle.
- OPCODE, MM and IR change only on the ACK edge and are stable otherwise.
- wr_rise in WAIT_ACK: ignored, no queuing.
- Branch target computation:
  - sext(IMM) is IMM[15:0] sign-extended to ADDR_W (truncated when ADDR_W<16).
  - Relative target = PC+sext(IMM), using the already-incremented PC. Wraps mod 2^ADDR_W.
  - Absolute target = IMM[ADDR_W-1:0].
- Branch in IDLE: on sel_rise, PC<=target at that edge.
- Branch in WAIT_ACK (sel_rise): capture BR_SEL into a pending-branch flag.
  - On the ACK edge, load IR as usual; suppress the +1 and compute the target from the new IR and the old PC+1.
  - Clear the flag.
- Branch on the same edge as ACK: treated as pending, i.e. the rule above.
- wr_rise and sel_rise on the same edge in IDLE: branch first. The fetch is issued at the new target, and IMEM_ADDR reflects the target.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT_ACK.
  - If no ACK arrives within TIMEOUT cycles: drop IMEM_REQ, load IR=0 (noop), leave PC unchanged, set FETCH_ERR (sticky until reset/PC_RST), return to IDLE. A pending branch is discarded.
- Without the macro: waits forever; FETCH_ERR=0; no counter logic.

Decomposition:
- cpu_pkg holds:
  - opcode constants (noop=0, lod=1, str=2, bra=4, brr=5, bne=6, alu_op=8, hlt=15);
  - am_imm=8;
  - IR field positions (OPCODE, MM, IMM);
  - fetch state enum (IDLE, WAIT_ACK).
- One sub-module: pc_next_calc, a combinational block computing next PC from PC, IMM, BR_SEL, the increment and branch enables. It is shared with the controller-side tests.

Test Plan:
- Reset release: RST_F 0->1 with RESET_PC=0 -> PC=0, IR=0, OPCODE=0, IMEM_REQ=0, FETCH_BUSY=0.
- Basic fetch: wr_rise, ACK after 3 cycles, RDATA=0x8800_0005 -> IMEM_ADDR=0 held for 3 cycles; then OPCODE=8, MM=8, PC=1, FETCH_BUSY=0.
- Relative branch: PC=5, IR IMM=0xFFFE, BR_SEL=0, PC_SEL rise -> PC=3; holding PC_SEL high for 4 more cycles leaves PC=3.
- Absolute branch during fetch: PC=2, wr_rise, then PC_SEL rise with BR_SEL=1 before ACK, RDATA IMM=0x0040 -> PC=0x40, not 3.
- PC_RST mid-fetch: PC_RST pulse in WAIT_ACK, then ACK -> PC=RESET_PC, IR=0, late ACK ignored, IMEM_REQ=0.
- Timeout (macro on, TIMEOUT=15): wr_rise with no ACK -> after 15 cycles IMEM_REQ=0, IR=0, FETCH_ERR=1, PC unchanged.
